// File: rtl/merge_out_buffer_if.sv
// Handshake/data bundle between the bitonic merge network, the output buffer
// and the next merger level.
interface merge_out_buffer_if #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 8
);
    logic                         i_stall;
    logic                         i_switch_output;
    logic [16*DATA_WIDTH-1:0]     i_elems_0;
    logic [16*DATA_WIDTH-1:0]     i_elems_1;
    logic                         i_ready;
    logic [16*DATA_WIDTH-1:0]     o_data;
    logic                         o_valid;
    logic [$clog2(DEPTH+1)-1:0]   o_count;
    logic                         o_almost_full;
    logic                         o_done;
    logic                         o_overflow;

    modport slave (
        input  i_stall, i_switch_output, i_elems_0, i_elems_1, i_ready,
        output o_data, o_valid, o_count, o_almost_full, o_done, o_overflow
    );

    modport master (
        output i_stall, i_switch_output, i_elems_0, i_elems_1, i_ready,
        input  o_data, o_valid, o_count, o_almost_full, o_done, o_overflow
    );
endinterface

// File: rtl/merge_out_buffer.sv
// Tuple FIFO behind the 32-element merge network: captures one 16-record half
// per valid cycle, serves it downstream, and flags the all-zero terminator.
module merge_out_buffer #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 8,
    parameter int SLACK      = 6
) (
    input  logic                i_clk,
    input  logic                i_rst,
    merge_out_buffer_if.slave   bus
);
    localparam int TW = 16 * DATA_WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][TW-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]         term_q, term_d;
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     overflow_q, overflow_d;
    logic                     done_q, done_d;

    logic [TW-1:0] wr_tuple;
    logic          wr_en, rd_en, full, wr_acc;

    always_comb begin
        wr_tuple   = bus.i_switch_output ? bus.i_elems_1 : bus.i_elems_0;
        wr_en      = ~bus.i_stall;
        rd_en      = (count_q != '0) & bus.i_ready;
        full       = (count_q == CW'(DEPTH));
        // A full FIFO still accepts a write when the same cycle frees a slot.
        wr_acc     = wr_en & (~full | rd_en);

        mem_d      = mem_q;
        term_d     = term_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (wr_en & ~wr_acc);
        done_d     = rd_en & term_q[rd_ptr_q];

        if (wr_acc) begin
            mem_d[wr_ptr_q]  = wr_tuple;
            term_d[wr_ptr_q] = (wr_tuple == '0);
            wr_ptr_d         = wr_ptr_q + AW'(1);
        end
        if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);

        case ({wr_acc, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    // Storage and terminator flags are only meaningful below count, so no reset.
    always_ff @(posedge i_clk) begin
        mem_q  <= mem_d;
        term_q <= term_d;
    end

    assign bus.o_data        = mem_q[rd_ptr_q];
    assign bus.o_valid       = (count_q != '0);
    assign bus.o_count       = count_q;
    assign bus.o_almost_full = (count_q >= CW'(DEPTH - SLACK));
    assign bus.o_done        = done_q;
    assign bus.o_overflow    = overflow_q;
endmodule

// File: tb/tb_merge_out_buffer.sv
// Directed bench for merge_out_buffer: ordering, half select, full/overflow,
// sustained read+write at full, terminator pulse and async reset.
module tb_merge_out_buffer;
    localparam int DW = 128;
    localparam int DEPTH = 8;
    localparam int TW = 16 * DW;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    merge_out_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    merge_out_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SLACK(6)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [TW-1:0] tup(input int k);
        logic [TW-1:0] t;
        for (int i = 0; i < 16; i++) t[i*DW +: DW] = DW'(k * 1000 + i + 1);
        return t;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_stall = 1'b1;
        bus.i_switch_output = 1'b0;
        bus.i_elems_0 = '0;
        bus.i_elems_1 = '0;
        bus.i_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.o_valid); end
        checks++; if (bus.o_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.o_count); end
        checks++; if (bus.o_almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got %b exp 0", bus.o_almost_full); end
        checks++; if (bus.o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.o_done); end
        checks++; if (bus.o_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", bus.o_overflow); end
    endtask

    task automatic test_order();
        for (int k = 1; k <= 3; k++) begin
            bus.i_stall = 1'b0;
            bus.i_elems_0 = tup(k);
            tick();
            checks++; if (bus.o_count !== 4'(k)) begin errors++; $display("FAIL order_count got %0d exp %0d", bus.o_count, k); end
            checks++; if (bus.o_data !== tup(1)) begin errors++; $display("FAIL order_head got %h exp %h", bus.o_data[63:0], tup(1) >> 0); end
        end
        bus.i_stall = 1'b1;
        bus.i_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            checks++; if (bus.o_data !== tup(k)) begin errors++; $display("FAIL order_pop%0d got %h exp %h", k, bus.o_data[63:0], tup(k) & 64'hffff_ffff_ffff_ffff); end
            tick();
        end
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL order_empty got %b exp 0", bus.o_valid); end
        bus.i_ready = 1'b0;
    endtask

    task automatic test_switch();
        bus.i_stall = 1'b0;
        bus.i_switch_output = 1'b1;
        bus.i_elems_0 = tup(50);
        bus.i_elems_1 = tup(51);
        tick();
        idle_inputs();
        checks++; if (bus.o_data !== tup(51)) begin errors++; $display("FAIL switch_data got %h exp %h", bus.o_data[63:0], tup(51) & 64'hffff_ffff_ffff_ffff); end
        checks++; if (bus.o_count !== 4'd1) begin errors++; $display("FAIL switch_count got %0d exp 1", bus.o_count); end
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
    endtask

    task automatic test_full_overflow();
        for (int k = 1; k <= 8; k++) begin
            bus.i_stall = 1'b0;
            bus.i_elems_0 = tup(100 + k);
            tick();
            checks++; if (bus.o_almost_full !== (k >= 2)) begin errors++; $display("FAIL af_at_%0d got %b exp %b", k, bus.o_almost_full, k >= 2); end
        end
        checks++; if (bus.o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_before got %b exp 0", bus.o_overflow); end
        bus.i_elems_0 = tup(109);
        tick();
        bus.i_stall = 1'b1;
        checks++; if (bus.o_count !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d exp 8", bus.o_count); end
        checks++; if (bus.o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", bus.o_overflow); end
        bus.i_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            checks++; if (bus.o_data !== tup(100 + k)) begin errors++; $display("FAIL full_pop%0d got %h exp %h", k, bus.o_data[63:0], tup(100 + k) & 64'hffff_ffff_ffff_ffff); end
            tick();
        end
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL ninth_absent valid got %b exp 0", bus.o_valid); end
        checks++; if (bus.o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", bus.o_overflow); end
        bus.i_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            bus.i_stall = 1'b0;
            bus.i_elems_0 = tup(200 + k);
            tick();
        end
        checks++; if (bus.o_count !== 4'd8) begin errors++; $display("FAIL b2b_fill got %0d exp 8", bus.o_count); end
        bus.i_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            bus.i_elems_0 = tup(300 + k);
            checks++; if (bus.o_data !== tup(200 + k)) begin errors++; $display("FAIL b2b_head%0d got %h exp %h", k, bus.o_data[63:0], tup(200 + k) & 64'hffff_ffff_ffff_ffff); end
            tick();
            checks++; if (bus.o_count !== 4'd8) begin errors++; $display("FAIL b2b_count%0d got %0d exp 8", k, bus.o_count); end
        end
        bus.i_stall = 1'b1;
        for (int k = 5; k <= 12; k++) begin
            int id;
            id = (k <= 8) ? 200 + k : 300 + (k - 8);
            checks++; if (bus.o_data !== tup(id)) begin errors++; $display("FAIL b2b_pop%0d got %h exp %h", k, bus.o_data[63:0], tup(id) & 64'hffff_ffff_ffff_ffff); end
            tick();
        end
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", bus.o_valid); end
        checks++; if (bus.o_overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf got %b exp 0", bus.o_overflow); end
        bus.i_ready = 1'b0;
    endtask

    task automatic test_done();
        logic [TW-1:0] seq [3];
        logic exp_done [4];
        seq[0] = tup(400);
        seq[1] = '0;
        seq[2] = tup(401);
        exp_done[0] = 1'b0; exp_done[1] = 1'b1; exp_done[2] = 1'b0; exp_done[3] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.i_stall = 1'b0;
            bus.i_elems_0 = seq[k];
            tick();
            checks++; if (bus.o_done !== 1'b0) begin errors++; $display("FAIL done_push%0d got %b exp 0", k, bus.o_done); end
        end
        bus.i_stall = 1'b1;
        bus.i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (bus.o_done !== exp_done[k]) begin errors++; $display("FAIL done_pop%0d got %b exp %b", k, bus.o_done, exp_done[k]); end
        end
        bus.i_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int k = 1; k <= 5; k++) begin
            bus.i_stall = 1'b0;
            bus.i_elems_0 = tup(500 + k);
            tick();
        end
        checks++; if (bus.o_count !== 4'd5) begin errors++; $display("FAIL arst_pre got %0d exp 5", bus.o_count); end
        #2;
        i_rst = 1'b1;
        #1;
        checks++; if (bus.o_count !== 4'd0) begin errors++; $display("FAIL arst_count got %0d exp 0", bus.o_count); end
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", bus.o_valid); end
        checks++; if (bus.o_almost_full !== 1'b0) begin errors++; $display("FAIL arst_af got %b exp 0", bus.o_almost_full); end
        idle_inputs();
        tick();
        i_rst = 1'b0;
        bus.i_stall = 1'b0;
        bus.i_elems_0 = tup(600);
        tick();
        bus.i_stall = 1'b1;
        checks++; if (bus.o_count !== 4'd1) begin errors++; $display("FAIL arst_fresh_count got %0d exp 1", bus.o_count); end
        checks++; if (bus.o_data !== tup(600)) begin errors++; $display("FAIL arst_fresh_data got %h exp %h", bus.o_data[63:0], tup(600) & 64'hffff_ffff_ffff_ffff); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_order();
        test_switch();
        test_full_overflow();
        test_back_to_back();
        test_done();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
